uart_rx: RTL and testbench

//   UART receiver (8N1, LSB first); receive-side counterpart of the UART TX path.

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop recovery with a one-deep
// valid/ready holding register and single-cycle framing-error / overrun pulses.
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic [IW-1:0]          r_bit_idx;
    logic [IW-1:0]          w_idx_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS:0]     w_shift_cat;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_rxs;
    logic                   w_shift_en;
    logic                   w_stop_ok;
    logic                   w_stop_bad;

    assign w_rxs       = r_sync2;
    assign w_shift_cat = {w_rxs, r_shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_en   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        if (baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        w_state_next = S_START;
                        w_cnt_next   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                        w_state_next = w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
                        w_shift_en = 1'b1;
                        if (r_bit_idx == IDX_LAST) w_state_next = S_STOP;
                        else                       w_idx_next   = r_bit_idx + 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = '0;
                        // Returning to IDLE at mid-stop lets an immediately following start bit be seen.
                        if (w_rxs) begin
                            w_stop_ok    = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_stop_bad   = 1'b1;
                            w_state_next = S_BREAK;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rxs) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_idx_next;
            if (w_shift_en) r_shift <= w_shift_cat[DATA_BITS:1];
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_stop_ok & r_valid & ~rx_ready;
            // A load in the same clk as an accept keeps valid high with the new byte.
            if (w_stop_ok && (!r_valid || rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, outputs observed
// on the falling clock edge and compared against hand-computed bytes and pulse counts.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int tick_ph = 0;

    int   n_vcyc = 0;
    int   n_fe = 0;
    int   n_ov = 0;
    logic [7:0] got[$];

    uart_rx #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial baud_tick = 1'b1;
    always begin
        @(posedge clk);
        #1;
        if (tick_div <= 1) begin
            baud_tick = 1'b1;
        end else begin
            tick_ph   = (tick_ph + 1) % tick_div;
            baud_tick = (tick_ph == 0);
        end
    end

    // Falling-edge monitor: counts valid cycles and pulses, records accepted bytes.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) n_vcyc++;
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input int n);
        rx_serial = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        int bp;
        bp = 8 * tick_div;
        drive(1'b0, bp);
        for (int i = 0; i < 8; i++) drive(d[i], bp);
        drive(stop_bit, bp);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_serial = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid/fe/ov/busy=%b data=%h, required 0000 / 00",
                     {rx_valid, frame_err, overrun, busy}, rx_data);
        end
        rst = 1'b0;
        drive(1'b1, 4);
        checks++;
        if (rx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b busy=%b, required 0 0", rx_valid, busy);
        end
    endtask

    task automatic test_single_frame;
        int v0, f0, o0, g0;
        rx_ready = 1'b1;
        v0 = n_vcyc; f0 = n_fe; o0 = n_ov; g0 = got.size();
        send_frame(8'h41, 1'b1);
        drive(1'b1, 16);
        checks++;
        if (got.size() != g0 + 1 || got[g0] !== 8'h41) begin
            errors++;
            $display("FAIL single_byte: got %0d bytes (first %h), required 1 byte 41",
                     got.size() - g0, (got.size() > g0) ? got[g0] : 8'hxx);
        end
        checks++;
        if (n_vcyc - v0 != 1) begin
            errors++;
            $display("FAIL single_valid_len: valid high %0d clks, required 1", n_vcyc - v0);
        end
        checks++;
        if (n_fe != f0 || n_ov != o0) begin
            errors++;
            $display("FAIL single_flags: fe=%0d ov=%0d pulses, required 0 0", n_fe - f0, n_ov - o0);
        end
        checks++;
        if (rx_data !== 8'h41) begin
            errors++;
            $display("FAIL single_data_hold: rx_data=%h, required 41", rx_data);
        end
    endtask

    task automatic test_glitch;
        int v0, f0, o0, k;
        v0 = n_vcyc; f0 = n_fe; o0 = n_ov;
        drive(1'b0, 2);
        rx_serial = 1'b1;
        k = 0;
        while (busy !== 1'b0 && k < 6) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: busy=%b after 6 clks, required 0", busy);
        end
        drive(1'b1, 16);
        checks++;
        if (n_vcyc != v0 || n_fe != f0 || n_ov != o0) begin
            errors++;
            $display("FAIL glitch_quiet: valid=%0d fe=%0d ov=%0d, required 0 0 0",
                     n_vcyc - v0, n_fe - f0, n_ov - o0);
        end
    endtask

    task automatic test_frame_error;
        int f0, o0, g0;
        rx_ready = 1'b1;
        f0 = n_fe; o0 = n_ov; g0 = got.size();
        send_frame(8'h55, 1'b0);
        drive(1'b0, 40);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: busy=%b while line low, required 1", busy);
        end
        drive(1'b1, 16);
        checks++;
        if (n_fe - f0 != 1 || got.size() != g0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err: fe pulses=%0d bytes=%0d busy=%b, required 1 0 0",
                     n_fe - f0, got.size() - g0, busy);
        end
        send_frame(8'hA3, 1'b1);
        drive(1'b1, 16);
        checks++;
        if (got.size() != g0 + 1 || got[g0] !== 8'hA3 || n_fe - f0 != 1 || n_ov != o0) begin
            errors++;
            $display("FAIL after_break: bytes=%0d first=%h fe=%0d ov=%0d, required 1 A3 1 0",
                     got.size() - g0, (got.size() > g0) ? got[g0] : 8'hxx, n_fe - f0, n_ov - o0);
        end
    endtask

    task automatic test_overrun;
        int f0, o0, g0;
        rx_ready = 1'b0;
        f0 = n_fe; o0 = n_ov; g0 = got.size();
        send_frame(8'h12, 1'b1);
        drive(1'b1, 8);
        send_frame(8'h34, 1'b1);
        drive(1'b1, 16);
        checks++;
        if (n_ov - o0 != 1 || n_fe != f0) begin
            errors++;
            $display("FAIL overrun_pulse: ov=%0d fe=%0d, required 1 0", n_ov - o0, n_fe - f0);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h12 || got.size() != g0) begin
            errors++;
            $display("FAIL overrun_hold: valid=%b data=%h, required 1 12", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h12 || got.size() != g0 + 1) begin
            errors++;
            $display("FAIL overrun_accept: valid=%b data=%h accepted=%0d, required 0 12 1",
                     rx_valid, rx_data, got.size() - g0);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        int g0;
        rx_ready = 1'b1;
        d = 8'h9C;
        drive(1'b0, 8);
        for (int i = 0; i < 4; i++) drive(d[i], 8);
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset: valid/fe/ov/busy=%b data=%h, required 0000 / 00",
                     {rx_valid, frame_err, overrun, busy}, rx_data);
        end
        rx_serial = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        g0 = got.size();
        drive(1'b1, 8);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 16);
        checks++;
        if (got.size() != g0 + 1 || got[g0] !== 8'hFF) begin
            errors++;
            $display("FAIL after_reset_frame: bytes=%0d first=%h, required 1 FF",
                     got.size() - g0, (got.size() > g0) ? got[g0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back(input int div);
        int f0, o0, g0;
        tick_div = div;
        rx_ready = 1'b1;
        drive(1'b1, 16 * div);
        f0 = n_fe; o0 = n_ov; g0 = got.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 16 * div);
        checks++;
        if (got.size() != g0 + 2 || got[g0] !== 8'h00 || got[g0+1] !== 8'hFF) begin
            errors++;
            $display("FAIL back_to_back_div%0d: bytes=%0d first=%h second=%h, required 2 00 FF",
                     div, got.size() - g0, (got.size() > g0) ? got[g0] : 8'hxx,
                     (got.size() > g0 + 1) ? got[g0+1] : 8'hxx);
        end
        checks++;
        if (n_fe != f0 || n_ov != o0) begin
            errors++;
            $display("FAIL back_to_back_flags_div%0d: fe=%0d ov=%0d, required 0 0",
                     div, n_fe - f0, n_ov - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_midframe();
        test_back_to_back(1);
        test_back_to_back(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
